// File: rtl/spi_axi_lite_mailbox.sv
// AXI-Lite register block for the SPI bridge: four scratch words, an outbound
// word mailbox FIFO with interrupt, a control register and a constant ID.
package spi_axi_lite_mailbox_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axi_lite_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_ax_t aw;
        logic         aw_valid;
        axi_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_lite_b_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_lite_r_t r;
        logic        r_valid;
    } axi_lite_rsp_t;
endpackage

module spi_axi_lite_mailbox #(
    parameter type         axi_lite_req_t = spi_axi_lite_mailbox_pkg::axi_lite_req_t,
    parameter type         axi_lite_rsp_t = spi_axi_lite_mailbox_pkg::axi_lite_rsp_t,
    parameter int unsigned FifoDepth      = 8,
    parameter logic [31:0] IdValue        = 32'h5350_4D42
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  axi_lite_req_t axi_lite_req_i,
    output axi_lite_rsp_t axi_lite_rsp_o,
    output logic [31:0]   mbox_data_o,
    output logic          mbox_valid_o,
    input  logic          mbox_ready_i,
    output logic          irq_o
);
    localparam int unsigned  PtrW       = $clog2(FifoDepth);
    localparam logic [PtrW:0] FullCount = FifoDepth[PtrW:0];
    localparam logic [1:0]   RespOkay   = 2'b00;
    localparam logic [1:0]   RespSlverr = 2'b10;
    localparam logic [1:0]   RespDecerr = 2'b11;

    logic            wr_ready_reg, b_valid_reg, ar_ready_reg, r_valid_reg;
    logic [1:0]      b_resp_reg, r_resp_reg;
    logic [31:0]     r_data_reg;
    logic [31:0]     scratch_reg [4];
    logic            irq_en_reg;
    logic [31:0]     fifo_mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PtrW:0]   count_reg;

    logic [5:0]  aw_idx, ar_idx;
    logic        wr_fire, rd_fire, fifo_full, fifo_empty, push, pop, flush;
    logic [31:0] wr_mask, wdata, status, rd_data;
    logic [1:0]  wr_resp, rd_resp;
    logic [3:0]  strb;
    logic        unused_bits;

    assign aw_idx  = axi_lite_req_i.aw.addr[7:2];
    assign ar_idx  = axi_lite_req_i.ar.addr[7:2];
    assign wdata   = axi_lite_req_i.w.data;
    assign strb    = axi_lite_req_i.w.strb;
    assign wr_fire = wr_ready_reg & axi_lite_req_i.aw_valid & axi_lite_req_i.w_valid;
    assign rd_fire = ar_ready_reg & axi_lite_req_i.ar_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_mask[gi*8 +: 8] = {8{strb[gi]}};
        end
    endgenerate

    assign fifo_empty   = (count_reg == '0);
    assign fifo_full    = (count_reg == FullCount);
    assign status       = {16'h0, 8'(count_reg), 6'h0, fifo_full, fifo_empty};
    assign mbox_valid_o = ~fifo_empty;
    assign mbox_data_o  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_reg];
    assign irq_o        = irq_en_reg & ~fifo_empty;
    assign pop          = mbox_valid_o & mbox_ready_i;

    always_comb begin
        wr_resp = RespOkay;
        push    = 1'b0;
        flush   = 1'b0;
        if (aw_idx[5:3] != 3'd0) begin
            wr_resp = RespDecerr;
        end else begin
            case (aw_idx[2:0])
                3'd4: begin
                    if (strb == 4'hF && !fifo_full) push = wr_fire;
                    else wr_resp = RespSlverr;
                end
                3'd5, 3'd7: wr_resp = RespSlverr;
                3'd6: flush = wr_fire & strb[0] & wdata[1];
                default: ;
            endcase
        end
    end

    // STATUS is captured here, at AR acceptance, not when R is returned.
    always_comb begin
        rd_data = 32'h0;
        rd_resp = RespOkay;
        if (ar_idx[5:3] != 3'd0) begin
            rd_resp = RespDecerr;
        end else begin
            case (ar_idx[2:0])
                3'd4:    rd_resp = RespSlverr;
                3'd5:    rd_data = status;
                3'd6:    rd_data = {31'h0, irq_en_reg};
                3'd7:    rd_data = IdValue;
                default: rd_data = scratch_reg[ar_idx[1:0]];
            endcase
        end
    end

    // Ready is registered and pulses for a single cycle once both valids are seen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ready_reg <= 1'b0;
            b_valid_reg  <= 1'b0;
            b_resp_reg   <= RespOkay;
            ar_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_resp_reg   <= RespOkay;
            r_data_reg   <= 32'h0;
        end else begin
            wr_ready_reg <= axi_lite_req_i.aw_valid & axi_lite_req_i.w_valid
                            & ~b_valid_reg & ~wr_ready_reg;
            ar_ready_reg <= axi_lite_req_i.ar_valid & ~r_valid_reg & ~ar_ready_reg;
            if (wr_fire) begin
                b_valid_reg <= 1'b1;
                b_resp_reg  <= wr_resp;
            end else if (axi_lite_req_i.b_ready) begin
                b_valid_reg <= 1'b0;
            end
            if (rd_fire) begin
                r_valid_reg <= 1'b1;
                r_resp_reg  <= rd_resp;
                r_data_reg  <= rd_data;
            end else if (axi_lite_req_i.r_ready) begin
                r_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) scratch_reg[i] <= 32'h0;
            irq_en_reg <= 1'b0;
        end else if (wr_fire && aw_idx[5:3] == 3'd0) begin
            if (!aw_idx[2])
                scratch_reg[aw_idx[1:0]] <= (scratch_reg[aw_idx[1:0]] & ~wr_mask) | (wdata & wr_mask);
            if (aw_idx[2:0] == 3'd6 && strb[0])
                irq_en_reg <= wdata[0];
        end
    end

    // Flush wins over any pop in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_reg] <= wdata;
    end

    always_comb begin
        axi_lite_rsp_o          = '0;
        axi_lite_rsp_o.aw_ready = wr_ready_reg;
        axi_lite_rsp_o.w_ready  = wr_ready_reg;
        axi_lite_rsp_o.b.resp   = b_resp_reg;
        axi_lite_rsp_o.b_valid  = b_valid_reg;
        axi_lite_rsp_o.ar_ready = ar_ready_reg;
        axi_lite_rsp_o.r.data   = r_data_reg;
        axi_lite_rsp_o.r.resp   = r_resp_reg;
        axi_lite_rsp_o.r_valid  = r_valid_reg;
    end

    assign unused_bits = ^{axi_lite_req_i.aw.addr[31:8], axi_lite_req_i.aw.addr[1:0],
                           axi_lite_req_i.aw.prot, axi_lite_req_i.ar.addr[31:8],
                           axi_lite_req_i.ar.addr[1:0], axi_lite_req_i.ar.prot};
endmodule

// File: tb/tb_spi_axi_lite_mailbox.sv
// Directed scenarios plus randomized register/mailbox traffic for spi_axi_lite_mailbox,
// checked against a queue-based model of the register map.
module tb_spi_axi_lite_mailbox;
    import spi_axi_lite_mailbox_pkg::*;

    localparam int          Depth = 8;
    localparam logic [31:0] IdVal = 32'h5350_4D42;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    axi_lite_req_t req;
    axi_lite_rsp_t rsp;
    logic [31:0]   mbox_data;
    logic          mbox_valid, mbox_ready, irq;

    always #5 clk = ~clk;

    spi_axi_lite_mailbox #(
        .axi_lite_req_t(axi_lite_req_t),
        .axi_lite_rsp_t(axi_lite_rsp_t),
        .FifoDepth     (Depth),
        .IdValue       (IdVal)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .axi_lite_req_i(req),
        .axi_lite_rsp_o(rsp),
        .mbox_data_o   (mbox_data),
        .mbox_valid_o  (mbox_valid),
        .mbox_ready_i  (mbox_ready),
        .irq_o         (irq)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_scratch [4];
    bit          m_irq_en;
    logic [31:0] m_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_scratch[i] = 32'h0;
        m_irq_en = 1'b0;
        m_q.delete();
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx = int'(addr[7:2]);
        if (idx >= 8) return 2'b11;
        if (idx < 4) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_scratch[idx][b*8 +: 8] = data[b*8 +: 8];
            return 2'b00;
        end
        if (idx == 4) begin
            if (strb == 4'hF && m_q.size() < Depth) begin
                m_q.push_back(data);
                return 2'b00;
            end
            return 2'b10;
        end
        if (idx == 6) begin
            if (strb[0]) begin
                m_irq_en = data[0];
                if (data[1]) m_q.delete();
            end
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                       output logic [1:0] resp);
        int idx = int'(addr[7:2]);
        data = 32'h0;
        resp = 2'b00;
        if (idx >= 8) resp = 2'b11;
        else if (idx < 4) data = m_scratch[idx];
        else if (idx == 4) resp = 2'b10;
        else if (idx == 5) data = {16'h0, 8'(m_q.size()), 6'h0, m_q.size() == Depth, m_q.size() == 0};
        else if (idx == 6) data = {31'h0, m_irq_en};
        else data = IdVal;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr_drive(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        req.aw.addr = addr;
        req.aw.prot = 3'h0;
        req.w.data  = data;
        req.w.strb  = strb;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
    endtask

    task automatic wr_handshake(input bit pop_too, input logic [31:0] exp_head);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp.aw_ready && rsp.w_ready) begin
                got = 1'b1;
                if (pop_too) begin
                    mbox_ready = 1'b1;
                    check("pop_with_push_head", mbox_data, exp_head);
                end
            end
            @(posedge clk); #1;
        end
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        mbox_ready   = 1'b0;
        check("aw_handshake_seen", 32'(got), 32'd1);
    endtask

    task automatic wr_collect(output logic [1:0] resp);
        bit got = 1'b0;
        resp = 2'bxx;
        req.b_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp.b_valid) begin
                got  = 1'b1;
                resp = rsp.b.resp;
            end
            @(posedge clk); #1;
        end
        req.b_ready = 1'b0;
        check("b_valid_seen", 32'(got), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit pop_too);
        logic [1:0]  exp, resp;
        logic [31:0] head = 32'h0;
        if (pop_too) head = m_q[0];
        exp = model_write(addr, data, strb);
        if (pop_too) m_q.pop_front();
        wr_drive(addr, data, strb);
        wr_handshake(pop_too, head);
        wr_collect(resp);
        check($sformatf("wr_resp@%h", addr), 32'(resp), 32'(exp));
    endtask

    task automatic rd_handshake();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp.ar_ready) got = 1'b1;
            @(posedge clk); #1;
        end
        req.ar_valid = 1'b0;
        check("ar_handshake_seen", 32'(got), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp, resp;
        bit got = 1'b0;
        model_read(addr, exp_data, exp_resp);
        req.ar.addr  = addr;
        req.ar.prot  = 3'h0;
        req.ar_valid = 1'b1;
        rd_handshake();
        data = 32'hx;
        resp = 2'bxx;
        req.r_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp.r_valid) begin
                got  = 1'b1;
                data = rsp.r.data;
                resp = rsp.r.resp;
            end
            @(posedge clk); #1;
        end
        req.r_ready = 1'b0;
        check("r_valid_seen", 32'(got), 32'd1);
        check($sformatf("rd_resp@%h", addr), 32'(resp), 32'(exp_resp));
        check($sformatf("rd_data@%h", addr), data, exp_data);
    endtask

    task automatic do_pop();
        mbox_ready = 1'b1;
        @(negedge clk);
        check("pop_valid", 32'(mbox_valid), 32'd1);
        check("pop_data", mbox_data, m_q[0]);
        @(posedge clk); #1;
        mbox_ready = 1'b0;
        m_q.pop_front();
    endtask

    task automatic check_outputs();
        @(negedge clk);
        check("irq", 32'(irq), 32'(m_irq_en && m_q.size() > 0));
        check("mbox_valid", 32'(mbox_valid), 32'(m_q.size() > 0));
        check("mbox_data", mbox_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, r, data;
        logic [7:0]  off;
        logic [3:0]  strb;
        logic [1:0]  resp, exp1, exp2;
        int          op;

        req = '0;
        mbox_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_aw_ready", 32'(rsp.aw_ready), 32'd0);
        check("rst_ar_ready", 32'(rsp.ar_ready), 32'd0);
        check("rst_b_valid", 32'(rsp.b_valid), 32'd0);
        check("rst_r_valid", 32'(rsp.r_valid), 32'd0);
        check("rst_mbox_valid", 32'(mbox_valid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_mbox_data", mbox_data, 32'h0);
        @(posedge clk); #1;

        // Byte-strobed scratch write
        do_write(32'h00, 32'h1234_5678, 4'hF, 1'b0);
        do_write(32'h00, 32'hA5A5_A5A5, 4'b0011, 1'b0);
        do_read(32'h00, d);
        check("strb_merge_data", d, 32'h1234_A5A5);

        // Fill to full, overflow, drain
        for (int i = 0; i < 8; i++) do_write(32'h10, 32'(i), 4'hF, 1'b0);
        do_write(32'h10, 32'h99, 4'hF, 1'b0);
        do_read(32'h14, d);
        check("full_status", d, 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", m_q[0], 32'(i));
            do_pop();
        end
        do_read(32'h14, d);
        check("empty_status", d, 32'h0000_0001);

        // Simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++) do_write(32'h10, 32'h100 + 32'(i), 4'hF, 1'b0);
        do_write(32'h10, 32'h103, 4'hF, 1'b1);
        do_read(32'h14, d);
        check("push_pop_count", d, 32'h0000_0300);
        for (int i = 0; i < 3; i++) do_pop();

        // Interrupt and flush
        do_write(32'h18, 32'h1, 4'hF, 1'b0);
        do_write(32'h10, 32'hBEEF, 4'hF, 1'b0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'd1);
        @(posedge clk); #1;
        do_write(32'h18, 32'h3, 4'hF, 1'b0);
        check_outputs();
        do_read(32'h18, d);
        check("ctrl_after_flush", d, 32'h1);
        do_write(32'h18, 32'h0, 4'hF, 1'b0);

        // Error responses and B backpressure
        do_read(32'h20, d);
        do_write(32'h1C, 32'h0BAD_0BAD, 4'hF, 1'b0);
        do_read(32'h1C, d);
        check("id_value", d, IdVal);
        exp1 = model_write(32'h1C, 32'h1111_2222, 4'hF);
        wr_drive(32'h1C, 32'h1111_2222, 4'hF);
        wr_handshake(1'b0, 32'h0);
        exp2 = model_write(32'h04, 32'hCAFE_F00D, 4'hF);
        wr_drive(32'h04, 32'hCAFE_F00D, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_b_valid", 32'(rsp.b_valid), 32'd1);
            check("hold_b_resp", 32'(rsp.b.resp), 32'(exp1));
            check("hold_aw_ready", 32'(rsp.aw_ready), 32'd0);
            @(posedge clk); #1;
        end
        wr_collect(resp);
        check("held_b_resp", 32'(resp), 32'(exp1));
        wr_handshake(1'b0, 32'h0);
        wr_collect(resp);
        check("second_b_resp", 32'(resp), 32'(exp2));

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            op  = int'($urandom_range(0, 9));
            r   = $urandom;
            off = 8'($urandom_range(0, 15) * 4);
            if (r[3:2] == 2'b00) off = 8'h10;
            if (op < 5) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                if (off == 8'h10 && r[4]) strb = 4'hF;
                do_write({r[31:8], off[7:2], r[1:0]}, data, strb, 1'b0);
            end else if (op < 9) begin
                do_read({r[31:8], off[7:2], r[1:0]}, d);
            end else if (m_q.size() > 0) begin
                do_pop();
            end
            check_outputs();
        end

        // Reset with an R response pending
        do_write(32'h18, 32'h1, 4'hF, 1'b0);
        do_write(32'h10, 32'h77, 4'hF, 1'b0);
        do_write(32'h08, 32'h55, 4'hF, 1'b0);
        req.ar.addr  = 32'h08;
        req.ar_valid = 1'b1;
        rd_handshake();
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (rsp.r_valid) got = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check("r_pending_seen", 32'(got), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("post_rst_r_valid", 32'(rsp.r_valid), 32'd0);
        check("post_rst_b_valid", 32'(rsp.b_valid), 32'd0);
        check("post_rst_mbox_valid", 32'(mbox_valid), 32'd0);
        check("post_rst_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) do_read(32'(a * 4), d);
        do_read(32'h14, d);
        do_read(32'h18, d);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
